// File: rtl/muon_pattern_gen.sv
// muon_pattern_gen
//   Burst generator that emulates a muon crossing a stack of detector planes.
//   Each event issues a one-cycle trigger_o. Channel i then pulses for
//   pulse_len cycles, starting delay + i*step cycles after the trigger. All
//   pulses are clipped to the event window of period cycles.
//
//   Optional feature: define PATGEN_LFSR_EN to gate the hit mask on every
//   event with a 16-bit maximal-length Galois LFSR (taps 0xB400, seed 16'hACE1).
//   The first event after reset uses the seed value. The LFSR advances once
//   per trigger.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start_i          start a burst (only taken in IDLE)
//   abort_i          drop the current burst; outputs clear next cycle
//   n_events_i       triggers per burst (0 -> straight to DONE)
//   period_i         cycles between triggers (0 and 1 both mean 1)
//   delay_i          trigger -> channel 0 delay
//   step_i           extra delay per channel index
//   pulse_len_i      channel pulse width (0 -> no pulses)
//   hit_mask_i       channels allowed to fire
//   trigger_o        one-cycle pulse per event
//   signals_o        per-channel pulses
//   busy_o           high outside IDLE
//   done_o           one-cycle pulse on normal completion
//   event_cnt_o      triggers issued in the current/last burst (saturating)
module muon_pattern_gen #(
  parameter int N_CH  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] n_events_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [7:0]       step_i,
  input  logic [7:0]       pulse_len_i,
  input  logic [N_CH-1:0]  hit_mask_i,
  output logic             trigger_o,
  output logic [N_CH-1:0]  signals_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] event_cnt_o
);

  // Wide enough for delay + (N_CH-1)*step + pulse_len without wrap.
  localparam int OFF_W = CNT_W + 8 + $clog2(N_CH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_ev_q, n_ev_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [7:0]       step_q, step_d;
  logic [7:0]       plen_q, plen_d;
  logic [N_CH-1:0]  cfg_mask_q, cfg_mask_d;
  logic [N_CH-1:0]  ev_mask_d;

  logic             trig_q, trig_d;
  logic [N_CH-1:0]  sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             go;
  logic             win_end;
  logic [CNT_W-1:0] per_last;
  logic [OFF_W-1:0] t_ext, lo, hi;

`ifdef PATGEN_LFSR_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [N_CH-1:0]  emask_q, emask_d;
  logic [N_CH-1:0]  lfsr_rep;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      cnt_q      <= '0;
      n_ev_q     <= '0;
      per_q      <= '0;
      dly_q      <= '0;
      step_q     <= '0;
      plen_q     <= '0;
      cfg_mask_q <= '0;
      trig_q     <= 1'b0;
      sig_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PATGEN_LFSR_EN
      lfsr_q     <= 16'hACE1;
      emask_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      n_ev_q     <= n_ev_d;
      per_q      <= per_d;
      dly_q      <= dly_d;
      step_q     <= step_d;
      plen_q     <= plen_d;
      cfg_mask_q <= cfg_mask_d;
      trig_q     <= trig_d;
      sig_q      <= sig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PATGEN_LFSR_EN
      lfsr_q     <= lfsr_d;
      emask_q    <= emask_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin : next_state_comb
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_ev_d     = n_ev_q;
    per_d      = per_q;
    dly_d      = dly_q;
    step_d     = step_q;
    plen_d     = plen_q;
    cfg_mask_d = cfg_mask_q;
    go         = 1'b0;
    per_last   = (per_q <= CNT_W'(1)) ? '0 : per_q - CNT_W'(1);
    win_end    = (t_q >= per_last);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          go      = 1'b1;
          state_d = (n_events_i == '0) ? S_DONE : S_TRIG;
        end
      end
      S_TRIG, S_RUN: begin
        if (win_end) state_d = (cnt_q < n_ev_q) ? S_TRIG : S_DONE;
        else         state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
      go      = 1'b0;
    end

    if (go) begin
      n_ev_d     = n_events_i;
      per_d      = period_i;
      dly_d      = delay_i;
      step_d     = step_i;
      plen_d     = pulse_len_i;
      cfg_mask_d = hit_mask_i;
      cnt_d      = '0;
    end

    // Every TRIG cycle is a fresh event at t=0; RUN walks the window.
    t_d = (state_d == S_RUN) ? t_q + CNT_W'(1) : '0;

    if (state_d == S_TRIG && cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);

`ifdef PATGEN_LFSR_EN
    lfsr_rep = '0;
    for (int unsigned i = 0; i < N_CH; i++) lfsr_rep[i] = lfsr_q[i % 16];
    lfsr_d  = lfsr_q;
    emask_d = emask_q;
    if (state_d == S_TRIG) begin
      emask_d = cfg_mask_d & lfsr_rep;
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
    ev_mask_d = emask_d;
`else
    ev_mask_d = cfg_mask_d;
`endif
  end

  // Registered outputs are computed from the next state and next window
  // position, so they line up with the state they describe.
  always_comb begin : output_comb
    trig_d = (state_d == S_TRIG);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    sig_d  = '0;
    t_ext  = OFF_W'(t_d);
    lo     = '0;
    hi     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      lo = OFF_W'(dly_d) + OFF_W'(i) * OFF_W'(step_d);
      hi = lo + OFF_W'(plen_d);
      if ((state_d == S_TRIG || state_d == S_RUN) && ev_mask_d[i] &&
          t_ext >= lo && t_ext < hi)
        sig_d[i] = 1'b1;
    end
  end

  assign trigger_o   = trig_q;
  assign signals_o   = sig_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign event_cnt_o = cnt_q;

endmodule

// File: tb/tb_muon_pattern_gen.sv
module tb_muon_pattern_gen;

  logic        clk = 1'b0;
  logic        reset, start_i, abort_i;
  logic [15:0] n_events_i, period_i, delay_i;
  logic [7:0]  step_i, pulse_len_i;
  logic [15:0] hit_mask_i;
  logic        trigger_o, busy_o, done_o;
  logic [15:0] signals_o;
  logic [15:0] event_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    logic        trig;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

`ifdef PATGEN_LFSR_EN
  logic [15:0] lfsr_m = 16'hACE1;
`endif

  muon_pattern_gen #(.N_CH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .n_events_i(n_events_i), .period_i(period_i), .delay_i(delay_i),
    .step_i(step_i), .pulse_len_i(pulse_len_i), .hit_mask_i(hit_mask_i),
    .trigger_o(trigger_o), .signals_o(signals_o), .busy_o(busy_o),
    .done_o(done_o), .event_cnt_o(event_cnt_o)
  );

  always #5 clk = ~clk;

  // Monitor: any visible activity must match the next expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1 &&
          (busy_o === 1'b1 || done_o === 1'b1 || trigger_o === 1'b1 || signals_o !== 16'h0)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got trig=%0b sig=%h busy=%0b done=%0b cnt=%0d, want idle",
                   trigger_o, signals_o, busy_o, done_o, event_cnt_o);
        end else begin
          e = exp_q.pop_front();
          if ({trigger_o, signals_o, busy_o, done_o, event_cnt_o} !==
              {e.trig, e.sig, e.busy, e.done, e.cnt}) begin
            n_bad++;
            $display("FAIL %s: got trig=%0b sig=%h busy=%0b done=%0b cnt=%0d, want trig=%0b sig=%h busy=%0b done=%0b cnt=%0d",
                     e.nm, trigger_o, signals_o, busy_o, done_o, event_cnt_o,
                     e.trig, e.sig, e.busy, e.done, e.cnt);
          end
        end
      end
    end
  end

  task automatic push(input string nm, input logic tr, input logic [15:0] s,
                      input logic b, input logic d, input logic [15:0] c);
    exp_t e;
    e.nm = nm; e.trig = tr; e.sig = s; e.busy = b; e.done = d; e.cnt = c;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] sig_at(input int t, input int dly, input int stp,
                                         input int plen, input logic [15:0] m);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int lo;
      lo = dly + i * stp;
      if (m[i] && t >= lo && t < lo + plen) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Expected cycles of a burst; abort_ev=0 means it runs to completion,
  // otherwise the stream stops after (abort_ev, abort_t).
  task automatic push_burst(input string nm, input int n, input int per, input int dly,
                            input int stp, input int plen, input logic [15:0] m,
                            input int abort_ev, input int abort_t);
    int pe;
    logic [15:0] em;
    pe = (per <= 1) ? 1 : per;
    for (int e = 1; e <= n; e++) begin
      em = m;
`ifdef PATGEN_LFSR_EN
      em = m & lfsr_m;
      lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
`endif
      for (int t = 0; t < pe; t++) begin
        push(nm, t == 0, sig_at(t, dly, stp, plen, em), 1'b1, 1'b0, 16'(e));
        if (e == abort_ev && t == abort_t) return;
      end
    end
    if (abort_ev == 0) push(nm, 1'b0, 16'h0, 1'b1, 1'b1, 16'(n));
  endtask

  // Returns at the negedge of the TRIG cycle (cycle 0 of the burst).
  task automatic kick(input int n, input int per, input int dly, input int stp,
                      input int plen, input logic [15:0] m);
    @(negedge clk);
    n_events_i = 16'(n); period_i = 16'(per); delay_i = 16'(dly);
    step_i = 8'(stp); pulse_len_i = 8'(plen); hit_mask_i = m;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d cycles still pending, want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    n_events_i = '0; period_i = '0; delay_i = '0; step_i = '0; pulse_len_i = '0; hit_mask_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({trigger_o, signals_o, busy_o, done_o}), 32'h0);
    check("reset_cnt", 32'(event_cnt_o), 32'h0);
    reset = 1'b0;

`ifdef PATGEN_LFSR_EN
    // Reference LFSR sequence from seed ACE1.
    push("lfsr_e1", 1'b1, 16'hACE1, 1'b1, 1'b0, 16'd1); push("lfsr_e1", 1'b0, 16'h0, 1'b1, 1'b0, 16'd1);
    push("lfsr_e2", 1'b1, 16'hE270, 1'b1, 1'b0, 16'd2); push("lfsr_e2", 1'b0, 16'h0, 1'b1, 1'b0, 16'd2);
    push("lfsr_e3", 1'b1, 16'h7138, 1'b1, 1'b0, 16'd3); push("lfsr_e3", 1'b0, 16'h0, 1'b1, 1'b0, 16'd3);
    push("lfsr_e4", 1'b1, 16'h389C, 1'b1, 1'b0, 16'd4); push("lfsr_e4", 1'b0, 16'h0, 1'b1, 1'b0, 16'd4);
    push("lfsr_done", 1'b0, 16'h0, 1'b1, 1'b1, 16'd4);
    lfsr_m = 16'h1C4E;
    kick(4, 2, 0, 0, 1, 16'hFFFF);
    drain("lfsr", 20);
`endif

    // Single event with stagger; ch15 sits at t=35..37, done at t=40.
    push_burst("stagger", 1, 40, 5, 2, 3, 16'hFFFF, 0, 0);
    kick(1, 40, 5, 2, 3, 16'hFFFF);
    drain("stagger", 50);
    check("stagger_cnt", 32'(event_cnt_o), 32'd1);

    // Three events, pulses coincide with triggers.
    push_burst("multi", 3, 10, 0, 0, 1, 16'hA5C3, 0, 0);
    kick(3, 10, 0, 0, 1, 16'hA5C3);
    drain("multi", 40);
    check("multi_cnt", 32'(event_cnt_o), 32'd3);

    // Abort at t=4 of event 2.
    push_burst("abort", 3, 10, 2, 1, 3, 16'h0F0F, 2, 4);
    kick(3, 10, 2, 1, 3, 16'h0F0F);
    repeat (14) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'h0);
    drain("abort", 10);
    check("abort_cnt", 32'(event_cnt_o), 32'd2);

    // Abort wins over a simultaneous start: nothing runs, count not cleared.
    @(negedge clk);
    n_events_i = 16'd2; period_i = 16'd4; hit_mask_i = 16'hFFFF; pulse_len_i = 8'd1;
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    drain("abort_start", 5);
    check("abort_start_cnt", 32'(event_cnt_o), 32'd2);

    // start and config changes during RUN are ignored.
    push_burst("midstart", 2, 8, 1, 1, 2, 16'h00F0, 0, 0);
    kick(2, 8, 1, 1, 2, 16'h00F0);
    repeat (3) @(negedge clk);
    n_events_i = 16'd5; period_i = 16'd3; delay_i = 16'd0; step_i = 8'd0;
    pulse_len_i = 8'd7; hit_mask_i = 16'hFFFF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    drain("midstart", 30);

    // n_events=0: done one cycle after start, no trigger.
    push("zero_ev", 1'b0, 16'h0, 1'b1, 1'b1, 16'd0);
    kick(0, 5, 0, 0, 1, 16'hFFFF);
    drain("zero_ev", 5);
    check("zero_ev_cnt", 32'(event_cnt_o), 32'd0);

    // Period 1: trigger every cycle; pulse clipped to the single-cycle window.
    push_burst("per1", 4, 1, 0, 0, 2, 16'h0005, 0, 0);
    kick(4, 1, 0, 0, 2, 16'h0005);
    drain("per1", 10);

    // Period 0 behaves as 1; pulse_len 0 gives no pulses.
    push_burst("plen0", 3, 0, 0, 0, 0, 16'h0005, 0, 0);
    kick(3, 0, 0, 0, 0, 16'h0005);
    drain("plen0", 10);

    // Long pulses truncated at window end.
    push_burst("trunc", 2, 6, 3, 1, 8, 16'h0013, 0, 0);
    kick(2, 6, 3, 1, 8, 16'h0013);
    drain("trunc", 20);

    // Reset mid-burst discards it without done.
    push_burst("rst_mid", 2, 12, 1, 0, 4, 16'h8001, 1, 3);
    kick(2, 12, 1, 0, 4, 16'h8001);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef PATGEN_LFSR_EN
    lfsr_m = 16'hACE1;
`endif
    check("rst_mid_outputs", 32'({trigger_o, signals_o, busy_o, done_o}), 32'h0);
    check("rst_mid_cnt", 32'(event_cnt_o), 32'h0);
    drain("rst_mid", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
